// File: rtl/shift_unit_arbiter.sv
// ============================================================================
//  Module   : shift_unit_arbiter
//  Purpose  : Round-robin arbiter that lets two requesters share one 32-bit
//             barrel shifter, with a single registered response slot.
//             Optional rotate-right: SHIFT_UNIT_ARBITER_ROR_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [SHW-1:0]   a_shamt,
  input  logic [1:0]       a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [SHW-1:0]   b_shamt,
  input  logic [1:0]       b_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  localparam logic [1:0] c_op_srl = 2'b00;
  localparam logic [1:0] c_op_sra = 2'b01;
  localparam logic [1:0] c_op_sll = 2'b10;
  localparam logic [1:0] c_op_ror = 2'b11;
  localparam logic       c_id_a   = 1'b0;
  localparam logic       c_id_b   = 1'b1;

  logic             r_prio;
  logic             r_valid;
  logic             r_id;
  logic [WIDTH-1:0] r_data;

  logic             w_space;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept;
  logic             w_sel_b;
  logic [WIDTH-1:0] w_data;
  logic [SHW-1:0]   w_shamt;
  logic [1:0]       w_op;
  logic             w_fill;
  logic             w_wrap;
  logic [WIDTH-1:0] w_pre;
  logic [WIDTH-1:0] w_stage;
  logic [WIDTH-1:0] w_tmp;
  logic [WIDTH-1:0] w_result;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Arbitration never looks at operand data, keeping valid->ready paths short.
  assign w_space   = !r_valid || rsp_ready;
  assign w_grant_a = a_valid && (!b_valid || (r_prio == c_id_a));
  assign w_grant_b = b_valid && (!a_valid || (r_prio == c_id_b));
  assign a_ready   = w_space && w_grant_a;
  assign b_ready   = w_space && w_grant_b;
  assign w_accept  = a_ready || b_ready;
  assign w_sel_b   = w_grant_b;

  assign w_data  = w_sel_b ? b_data  : a_data;
  assign w_shamt = w_sel_b ? b_shamt : a_shamt;
  assign w_op    = w_sel_b ? b_op    : a_op;
  assign w_fill  = (w_op == c_op_sra) && w_data[WIDTH-1];

`ifdef SHIFT_UNIT_ARBITER_ROR_EN
  assign w_wrap = (w_op == c_op_ror);
`else
  assign w_wrap = 1'b0;
`endif

  // Right-shift-only datapath; left shifts are handled by reversing around it.
  always_comb begin
    w_pre   = (w_op == c_op_sll) ? bitrev(w_data) : w_data;
    w_stage = w_pre;
    w_tmp   = '0;
    for (int s = 0; s < SHW; s++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i + (1 << s) >= WIDTH) && !w_wrap)
          w_tmp[i] = w_fill;
        else
          w_tmp[i] = w_stage[SHW'((i + (1 << s)) % WIDTH)];
      end
      if (w_shamt[s]) w_stage = w_tmp;
    end
    w_result = (w_op == c_op_sll) ? bitrev(w_stage) : w_stage;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_prio  <= c_id_a;
      r_valid <= 1'b0;
      r_id    <= c_id_a;
      r_data  <= '0;
    end else if (w_accept) begin
      r_prio  <= w_sel_b ? c_id_a : c_id_b;
      r_valid <= 1'b1;
      r_id    <= w_sel_b;
      r_data  <= w_result;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
// ============================================================================
//  Module   : tb_shift_unit_arbiter
//  Purpose  : Directed and randomized self-checking bench for
//             shift_unit_arbiter (honours SHIFT_UNIT_ARBITER_ROR_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_arbiter;

  localparam logic [1:0] c_srl = 2'b00;
  localparam logic [1:0] c_sra = 2'b01;
  localparam logic [1:0] c_sll = 2'b10;
  localparam logic [1:0] c_ror = 2'b11;

`ifdef SHIFT_UNIT_ARBITER_ROR_EN
  localparam logic [31:0] c_op11_exp = 32'h8000_0000;
`else
  localparam logic [31:0] c_op11_exp = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rstb;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [31:0] a_data, b_data;
  logic [4:0]  a_shamt, b_shamt;
  logic [1:0]  a_op, b_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_valid, m_id, m_prio, m_space, m_ea, m_eb;
  logic [31:0] m_data;

  shift_unit_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rstb(rstb),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_shamt(a_shamt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_shamt(b_shamt), .b_op(b_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference shifter straight from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    case (op)
      2'b00:   return d >> sh;
      2'b01:   return $unsigned($signed(d) >>> sh);
      2'b10:   return d << sh;
      default:
`ifdef SHIFT_UNIT_ARBITER_ROR_EN
        return (sh == 5'd0) ? d : ((d >> sh) | (d << (6'd32 - {1'b0, sh})));
`else
        return d >> sh;
`endif
    endcase
  endfunction

  task automatic single_a(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] exp);
    a_valid = 1'b1; b_valid = 1'b0; rsp_ready = 1'b1;
    a_op = op; a_data = d; a_shamt = sh;
    #1;
    chk({tag, "_a_ready"}, a_ready, 1);
    tick;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_data"}, rsp_data, exp);
  endtask

  initial begin
    rstb = 1'b0; rsp_ready = 1'b0;
    a_valid = 1'b0; a_data = '0; a_shamt = '0; a_op = '0;
    b_valid = 1'b0; b_data = '0; b_shamt = '0; b_op = '0;
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_a_ready", a_ready, 0);
    tick;
    rstb = 1'b1;

    // Dual contention: strict A, B, A, B alternation from reset pointer A.
    rsp_ready = 1'b1;
    a_valid = 1'b1; a_op = c_srl; a_data = 32'hA5A5_0000; a_shamt = 5'd8;
    b_valid = 1'b1; b_op = c_sll; b_data = 32'h0000_00FF; b_shamt = 5'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("dual_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
      chk("dual_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
      tick;
      chk("dual_valid", rsp_valid, 1);
      chk("dual_id", rsp_id, (k % 2 == 0) ? 0 : 1);
      chk("dual_data", rsp_data, (k % 2 == 0) ? 32'h00A5_A500 : 32'h0000_0FF0);
    end

    single_a("sra", c_sra, 32'h8000_0000, 5'd4, 32'hF800_0000);
    single_a("srl", c_srl, 32'h8000_0000, 5'd4, 32'h0800_0000);
    single_a("sll31", c_sll, 32'h0000_0001, 5'd31, 32'h8000_0000);
    single_a("sll0", c_sll, 32'h1234_5678, 5'd0, 32'h1234_5678);
    single_a("sra31", c_sra, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
    single_a("op11", c_ror, 32'h0000_0001, 5'd1, c_op11_exp);

    // Backpressure: slot full, consumer stalled, both requesters waiting.
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op = c_srl; a_data = 32'h0000_F000; a_shamt = 5'd12;
    b_valid = 1'b1; b_op = c_sra; b_data = 32'hF000_0000; b_shamt = 5'd28;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_a_ready", a_ready, 0);
      chk("bp_b_ready", b_ready, 0);
      tick;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, c_op11_exp);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_b_ready", b_ready, 1);
    chk("bp_release_a_ready", a_ready, 0);
    tick;
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_id", rsp_id, 1);
    chk("bp_next_data", rsp_data, 32'hFFFF_FFFF);

    // Randomized traffic against the reference model.
    m_valid = 1'b1; m_id = 1'b1; m_data = 32'hFFFF_FFFF; m_prio = 1'b0;
    for (int n = 0; n < 400; n++) begin
      a_valid = 1'($urandom_range(0, 1)); a_op = 2'($urandom); a_data = $urandom;
      a_shamt = 5'($urandom);
      b_valid = 1'($urandom_range(0, 1)); b_op = 2'($urandom); b_data = $urandom;
      b_shamt = 5'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_space = !m_valid || rsp_ready;
      m_ea = m_space && a_valid && (!b_valid || m_prio == 1'b0);
      m_eb = m_space && b_valid && (!a_valid || m_prio == 1'b1);
      chk("rnd_a_ready", a_ready, m_ea);
      chk("rnd_b_ready", b_ready, m_eb);
      tick;
      if (m_ea || m_eb) begin
        m_data  = m_eb ? ref_shift(b_op, b_data, b_shamt) : ref_shift(a_op, a_data, a_shamt);
        m_id    = m_eb;
        m_prio  = m_ea;
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      chk("rnd_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_data", rsp_data, m_data);
      end
    end

    // Reset mid-transfer with a full slot and pointer left at B.
    a_valid = 1'b1; b_valid = 1'b0; rsp_ready = 1'b1;
    a_op = c_srl; a_data = 32'hDEAD_BEEF; a_shamt = 5'd0;
    tick;
    a_valid = 1'b0; rsp_ready = 1'b0;
    #2;
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_data", rsp_data, 32'hDEAD_BEEF);
    rstb = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_data", rsp_data, 0);
    chk("async_rst_id", rsp_id, 0);
    tick;
    rstb = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
    a_op = c_sll; a_data = 32'h0000_0003; a_shamt = 5'd1;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    tick;
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_data", rsp_data, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
